// File: rtl/alu_pkg.sv
// Shared decode constants for the integer ALU path: opcodes, ALU codes, FSM states, field positions.
// Also hosts the opcode decoder so the load/store decoders can share it.
package alu_pkg;

  // MicroBlaze numbers bit 0 as MSB; these are the equivalent LSB-0 positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 26;
  localparam int RD_MSB  = 25;
  localparam int RD_LSB  = 21;
  localparam int RA_MSB  = 20;
  localparam int RA_LSB  = 16;
  localparam int RB_MSB  = 15;
  localparam int RB_LSB  = 11;
  localparam int IMM_MSB = 15;
  localparam int IMM_LSB = 0;

  localparam int OPC_TYPEB_BIT = 3;
  localparam int OPC_KEEP_BIT  = 2;

  localparam logic [5:0] OPC_ADD    = 6'b000000;
  localparam logic [5:0] OPC_RSUB   = 6'b000001;
  localparam logic [5:0] OPC_ADDK   = 6'b000100;
  localparam logic [5:0] OPC_RSUBK  = 6'b000101;
  localparam logic [5:0] OPC_ADDI   = 6'b001000;
  localparam logic [5:0] OPC_RSUBI  = 6'b001001;
  localparam logic [5:0] OPC_ADDIK  = 6'b001100;
  localparam logic [5:0] OPC_RSUBIK = 6'b001101;
  localparam logic [5:0] OPC_OR     = 6'b100000;
  localparam logic [5:0] OPC_AND    = 6'b100001;
  localparam logic [5:0] OPC_XOR    = 6'b100010;
  localparam logic [5:0] OPC_ORI    = 6'b101000;
  localparam logic [5:0] OPC_ANDI   = 6'b101001;
  localparam logic [5:0] OPC_XORI   = 6'b101010;
  localparam logic [5:0] OPC_IMM    = 6'b101100;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_RSUB = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_EXEC, S_WB} state_t;

  typedef struct packed {
    logic       legal;
    logic       is_imm;
    logic       type_b;
    logic       keep_carry;
    logic [3:0] alu_op;
  } dec_t;

  function automatic dec_t decode(input logic [5:0] opc);
    dec_t d;
    d = '0;
    d.legal = 1'b1;
    case (opc)
      OPC_ADD, OPC_RSUB, OPC_ADDK, OPC_RSUBK,
      OPC_ADDI, OPC_RSUBI, OPC_ADDIK, OPC_RSUBIK: begin
        d.type_b     = opc[OPC_TYPEB_BIT];
        d.keep_carry = opc[OPC_KEEP_BIT];
        d.alu_op     = opc[0] ? ALU_RSUB : ALU_ADD;
      end
      OPC_OR, OPC_ORI: begin
        d.type_b = opc[OPC_TYPEB_BIT];
        d.alu_op = ALU_OR;
      end
      OPC_AND, OPC_ANDI: begin
        d.type_b = opc[OPC_TYPEB_BIT];
        d.alu_op = ALU_AND;
      end
      OPC_XOR, OPC_XORI: begin
        d.type_b = opc[OPC_TYPEB_BIT];
        d.alu_op = ALU_XOR;
      end
      OPC_IMM: d.is_imm = 1'b1;
      default: d.legal  = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_decode_fsm_if.sv
// Request/decode bundle between the instruction issuer (master) and the ALU decode FSM (slave).
interface alu_decode_fsm_if #(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
);
  logic              start;
  logic [31:0]       instr;
  logic              busy;
  logic              done;
  logic              illegal;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] ra;
  logic [REG_AW-1:0] rb;
  logic [DATA_W-1:0] imm_ext;
  logic              use_imm;
  logic [OP_W-1:0]   alu_op;
  logic              keep_carry;
  logic              read_ra;
  logic              read_rb;
  logic              write_rd;

  modport master (
    output start, instr,
    input  busy, done, illegal, rd, ra, rb, imm_ext, use_imm, alu_op, keep_carry,
           read_ra, read_rb, write_rd
  );

  modport slave (
    input  start, instr,
    output busy, done, illegal, rd, ra, rb, imm_ext, use_imm, alu_op, keep_carry,
           read_ra, read_rb, write_rd
  );
endinterface

// File: rtl/alu_imm_ext.sv
// Immediate extension: sign-extended imm16, or {imm_hi, imm16} after an IMM prefix.
module alu_imm_ext #(
  parameter int DATA_W = 32
) (
  input  logic [15:0]       imm16,
  input  logic [15:0]       imm_hi,
  input  logic              imm_valid,
  output logic [DATA_W-1:0] imm_ext
);
  logic [31:0] imm32;

  assign imm32   = imm_valid ? {imm_hi, imm16} : {{16{imm16[15]}}, imm16};
  assign imm_ext = DATA_W'($signed(imm32));
endmodule

// File: rtl/alu_decode_fsm.sv
// Decode/sequence FSM for integer ALU instructions: IDLE -> READ -> EXEC -> WB, or IDLE -> WB for IMM/illegal.
// All outputs registered; start is only sampled in IDLE.
module alu_decode_fsm
  import alu_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_AW = 5,
  parameter int OP_W   = 4
) (
  input logic clk,
  input logic reset,
  alu_decode_fsm_if.slave bus
);
  state_t state, state_nxt;
  dec_t   dec_in, dec_q, dec_cur;
  logic   accept;

  logic [REG_AW-1:0] rd_in, rd_q, ra_q, rb_q, rd_cur;
  logic [DATA_W-1:0] imm_ext_in, imm_ext_q;
  logic [15:0]       imm16_q, imm_hi;
  logic              imm_valid;
  logic              use_imm_q, keep_carry_q;
  logic [OP_W-1:0]   alu_op_q;

  logic busy_q, done_q, illegal_q, read_ra_q, read_rb_q, write_rd_q;
  logic busy_nxt, done_nxt, illegal_nxt, read_ra_nxt, read_rb_nxt, write_rd_nxt;

  assign accept = (state == S_IDLE) && bus.start;
  assign dec_in = decode(bus.instr[OPC_MSB:OPC_LSB]);
  assign rd_in  = REG_AW'(bus.instr[RD_MSB:RD_LSB]);

  // On the accept edge the registered outputs must reflect the incoming instruction.
  assign dec_cur = accept ? dec_in : dec_q;
  assign rd_cur  = accept ? rd_in : rd_q;

  alu_imm_ext #(.DATA_W(DATA_W)) u_imm_ext (
    .imm16    (bus.instr[IMM_MSB:IMM_LSB]),
    .imm_hi   (imm_hi),
    .imm_valid(imm_valid),
    .imm_ext  (imm_ext_in)
  );

  always_comb begin
    state_nxt    = state;
    busy_nxt     = 1'b0;
    done_nxt     = 1'b0;
    illegal_nxt  = 1'b0;
    read_ra_nxt  = 1'b0;
    read_rb_nxt  = 1'b0;
    write_rd_nxt = 1'b0;
    case (state)
      S_IDLE: if (bus.start) state_nxt = (dec_in.legal && !dec_in.is_imm) ? S_READ : S_WB;
      S_READ: state_nxt = S_EXEC;
      S_EXEC: state_nxt = S_WB;
      S_WB:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    busy_nxt     = (state_nxt != S_IDLE);
    read_ra_nxt  = (state_nxt == S_READ);
    read_rb_nxt  = (state_nxt == S_READ) && !dec_cur.type_b;
    done_nxt     = (state_nxt == S_WB);
    illegal_nxt  = done_nxt && !dec_cur.legal;
    // r0 is hard-wired zero, so a write to it is suppressed.
    write_rd_nxt = done_nxt && dec_cur.legal && !dec_cur.is_imm && (rd_cur != '0);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      illegal_q    <= 1'b0;
      read_ra_q    <= 1'b0;
      read_rb_q    <= 1'b0;
      write_rd_q   <= 1'b0;
      dec_q        <= '0;
      rd_q         <= '0;
      ra_q         <= '0;
      rb_q         <= '0;
      imm_ext_q    <= '0;
      use_imm_q    <= 1'b0;
      alu_op_q     <= '0;
      keep_carry_q <= 1'b0;
      imm16_q      <= '0;
      imm_hi       <= '0;
      imm_valid    <= 1'b0;
    end else begin
      state      <= state_nxt;
      busy_q     <= busy_nxt;
      done_q     <= done_nxt;
      illegal_q  <= illegal_nxt;
      read_ra_q  <= read_ra_nxt;
      read_rb_q  <= read_rb_nxt;
      write_rd_q <= write_rd_nxt;
      if (accept) begin
        dec_q        <= dec_in;
        rd_q         <= rd_in;
        ra_q         <= REG_AW'(bus.instr[RA_MSB:RA_LSB]);
        rb_q         <= REG_AW'(bus.instr[RB_MSB:RB_LSB]);
        imm_ext_q    <= imm_ext_in;
        use_imm_q    <= dec_in.type_b;
        alu_op_q     <= OP_W'(dec_in.alu_op);
        keep_carry_q <= dec_in.keep_carry;
        imm16_q      <= bus.instr[IMM_MSB:IMM_LSB];
      end
      // The prefix survives only until the next instruction of any kind completes.
      if (state == S_WB) begin
        imm_valid <= dec_q.is_imm;
        if (dec_q.is_imm) imm_hi <= imm16_q;
      end
    end
  end

  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.illegal    = illegal_q;
  assign bus.rd         = rd_q;
  assign bus.ra         = ra_q;
  assign bus.rb         = rb_q;
  assign bus.imm_ext    = imm_ext_q;
  assign bus.use_imm    = use_imm_q;
  assign bus.alu_op     = alu_op_q;
  assign bus.keep_carry = keep_carry_q;
  assign bus.read_ra    = read_ra_q;
  assign bus.read_rb    = read_rb_q;
  assign bus.write_rd   = write_rd_q;
endmodule

// File: tb/tb_alu_decode_fsm.sv
// Table-driven bench for alu_decode_fsm with a done-triggered scoreboard plus hand sequences for
// back-to-back issue and mid-operation reset.
module tb_alu_decode_fsm;

  typedef struct {
    logic [31:0] instr;
    logic        ill;
    logic        wr;
    logic [4:0]  rd;
    logic [4:0]  ra;
    logic [4:0]  rb;
    logic [31:0] imm;
    logic        use_imm;
    logic [3:0]  op;
    logic        kc;
    int          lat;
    int          n_ra;
    int          n_rb;
    logic        chk_alu;
    logic        chk_imm;
    int          start_cyc;
  } vec_t;

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;
  int   cnt_ra;
  int   cnt_rb;
  int   ra_cyc;
  vec_t sbq[$];
  vec_t tbl[21];

  alu_decode_fsm_if #(.DATA_W(32), .REG_AW(5), .OP_W(4)) bus ();

  alu_decode_fsm #(.DATA_W(32), .REG_AW(5), .OP_W(4)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic vec_t mk_alu(input logic [31:0] instr, input logic wr, input logic [4:0] rd,
                                  input logic [4:0] ra, input logic [4:0] rb, input logic [31:0] imm,
                                  input logic chk_imm, input logic use_imm, input logic [3:0] op,
                                  input logic kc, input int n_rb);
    vec_t v;
    v = '{instr: instr, ill: 1'b0, wr: wr, rd: rd, ra: ra, rb: rb, imm: imm, use_imm: use_imm,
          op: op, kc: kc, lat: 3, n_ra: 1, n_rb: n_rb, chk_alu: 1'b1, chk_imm: chk_imm, start_cyc: 0};
    return v;
  endfunction

  function automatic vec_t mk_ctl(input logic [31:0] instr, input logic ill, input logic [4:0] rd,
                                  input logic [4:0] ra, input logic [4:0] rb);
    vec_t v;
    v = '{instr: instr, ill: ill, wr: 1'b0, rd: rd, ra: ra, rb: rb, imm: 32'h0, use_imm: 1'b0,
          op: 4'd0, kc: 1'b0, lat: 1, n_ra: 0, n_rb: 0, chk_alu: 1'b0, chk_imm: 1'b0, start_cyc: 0};
    return v;
  endfunction

  // Scoreboard: every done pops the oldest expected record and is compared against it.
  always @(negedge clk) begin
    vec_t e;
    if (!reset) begin
      cnt_ra = 0;
      cnt_rb = 0;
    end else begin
      if (bus.read_ra) begin
        cnt_ra++;
        ra_cyc = cyc;
      end
      if (bus.read_rb) cnt_rb++;
      if (bus.write_rd && !bus.done) chk("write_rd_without_done", 64'(bus.write_rd), 64'd0);
      if (bus.done) begin
        if (sbq.size() == 0) begin
          chk("spurious_done", 64'(bus.done), 64'd0);
        end else begin
          e = sbq.pop_front();
          chk("illegal", 64'(bus.illegal), 64'(e.ill));
          chk("write_rd", 64'(bus.write_rd), 64'(e.wr));
          chk("rd", 64'(bus.rd), 64'(e.rd));
          chk("ra", 64'(bus.ra), 64'(e.ra));
          chk("rb", 64'(bus.rb), 64'(e.rb));
          chk("latency", 64'(cyc - e.start_cyc), 64'(e.lat));
          chk("read_ra_count", 64'(cnt_ra), 64'(e.n_ra));
          chk("read_rb_count", 64'(cnt_rb), 64'(e.n_rb));
          if (e.n_ra == 1) chk("read_ra_cycle", 64'(ra_cyc - e.start_cyc), 64'd1);
          if (e.chk_alu) begin
            chk("use_imm", 64'(bus.use_imm), 64'(e.use_imm));
            chk("alu_op", 64'(bus.alu_op), 64'(e.op));
            chk("keep_carry", 64'(bus.keep_carry), 64'(e.kc));
          end
          if (e.chk_imm) chk("imm_ext", 64'(bus.imm_ext), 64'(e.imm));
          cnt_ra = 0;
          cnt_rb = 0;
        end
      end
    end
  end

  task automatic push_exp(input vec_t v);
    vec_t t;
    t = v;
    t.start_cyc = cyc;
    sbq.push_back(t);
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    chk(name, 64'(sbq.size()), 64'd0);
    sbq.delete();
  endtask

  task automatic run(input vec_t v);
    @(negedge clk);
    bus.instr = v.instr;
    bus.start = 1'b1;
    push_exp(v);
    @(negedge clk);
    bus.start = 1'b0;
    drain("done_timeout");
  endtask

  function automatic logic [63:0] all_outs();
    return 64'({bus.busy, bus.done, bus.illegal, bus.rd, bus.ra, bus.rb, bus.imm_ext, bus.use_imm,
                bus.alu_op, bus.keep_carry, bus.read_ra, bus.read_rb, bus.write_rd});
  endfunction

  initial begin
    int idle;
    checks = 0;
    errors = 0;
    cnt_ra = 0;
    cnt_rb = 0;
    ra_cyc = 0;
    reset = 1'b0;
    bus.start = 1'b0;
    bus.instr = 32'h0;

    tbl[0]  = mk_alu(32'h30640005, 1, 5'd3, 5'd4, 5'd0,  32'h00000005, 1, 1, 4'd0, 1, 0); // ADDIK
    tbl[1]  = mk_alu(32'h2446FFFE, 1, 5'd2, 5'd6, 5'd31, 32'hFFFFFFFE, 1, 1, 4'd1, 0, 0); // RSUBI
    tbl[2]  = mk_alu(32'h00222800, 1, 5'd1, 5'd2, 5'd5,  32'h0,        0, 0, 4'd0, 0, 1); // ADD
    tbl[3]  = mk_ctl(32'hB0001234, 0, 5'd0, 5'd0, 5'd2);                                  // IMM
    tbl[4]  = mk_alu(32'hA0E85678, 1, 5'd7, 5'd8, 5'd10, 32'h12345678, 1, 1, 4'd3, 0, 0); // ORI
    tbl[5]  = mk_alu(32'hA5218000, 1, 5'd9, 5'd1, 5'd16, 32'hFFFF8000, 1, 1, 4'd2, 0, 0); // ANDI
    tbl[6]  = mk_ctl(32'hFC600000, 1, 5'd3, 5'd0, 5'd0);                                  // illegal
    tbl[7]  = mk_alu(32'h84011000, 0, 5'd0, 5'd1, 5'd2,  32'h0,        0, 0, 4'd2, 0, 1); // AND r0
    tbl[8]  = mk_alu(32'h88853000, 1, 5'd4, 5'd5, 5'd6,  32'h0,        0, 0, 4'd4, 0, 1); // XOR
    tbl[9]  = mk_alu(32'h154B6000, 1, 5'd10, 5'd11, 5'd12, 32'h0,      0, 0, 4'd1, 1, 1); // RSUBK
    tbl[10] = mk_ctl(32'hB000ABCD, 0, 5'd0, 5'd0, 5'd21);                                 // IMM
    tbl[11] = mk_ctl(32'hB0008765, 0, 5'd0, 5'd0, 5'd16);                                 // IMM again
    tbl[12] = mk_alu(32'hA8224321, 1, 5'd1, 5'd2, 5'd8,  32'h87654321, 1, 1, 4'd4, 0, 0); // XORI
    tbl[13] = mk_alu(32'h20200010, 1, 5'd1, 5'd0, 5'd0,  32'h00000010, 1, 1, 4'd0, 0, 0); // ADDI
    tbl[14] = mk_ctl(32'hB00000FF, 0, 5'd0, 5'd0, 5'd0);                                 // IMM
    tbl[15] = mk_alu(32'h00432000, 1, 5'd2, 5'd3, 5'd4,  32'h0,        0, 0, 4'd0, 0, 1); // ADD clears
    tbl[16] = mk_alu(32'h20200010, 1, 5'd1, 5'd0, 5'd0,  32'h00000010, 1, 1, 4'd0, 0, 0); // ADDI
    tbl[17] = mk_ctl(32'hB0007777, 0, 5'd0, 5'd0, 5'd14);                                 // IMM
    tbl[18] = mk_ctl(32'hFC600000, 1, 5'd3, 5'd0, 5'd0);                                  // illegal clears
    tbl[19] = mk_alu(32'h30640005, 1, 5'd3, 5'd4, 5'd0,  32'h00000005, 1, 1, 4'd0, 1, 0); // ADDIK
    tbl[20] = mk_alu(32'h34A68001, 1, 5'd5, 5'd6, 5'd16, 32'hFFFF8001, 1, 1, 4'd1, 1, 0); // RSUBIK

    repeat (3) @(negedge clk);
    #1;
    chk("reset_outputs", all_outs(), 64'd0);
    reset = 1'b1;

    for (int i = 0; i < 21; i++) run(tbl[i]);

    // start held high across three ALU ops: one accept every 4 cycles.
    @(negedge clk);
    bus.instr = tbl[2].instr;
    bus.start = 1'b1;
    push_exp(tbl[2]);
    idle = 0;
    #1;
    if (!bus.busy) idle++;
    for (int c = 1; c < 12; c++) begin
      @(negedge clk);
      #1;
      if (!bus.busy) idle++;
      if (c == 3) begin
        bus.instr = tbl[8].instr;
        push_exp(tbl[8]);
        sbq[sbq.size()-1].start_cyc = cyc + 1;
      end
      if (c == 7) begin
        bus.instr = tbl[9].instr;
        push_exp(tbl[9]);
        sbq[sbq.size()-1].start_cyc = cyc + 1;
      end
    end
    bus.start = 1'b0;
    chk("b2b_idle_cycles", 64'(idle), 64'd3);
    drain("b2b_done_timeout");

    // Reset during EXEC of an ALU op that follows an IMM prefix.
    run(tbl[3]);
    @(negedge clk);
    bus.instr = 32'h00222800;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    @(negedge clk);
    #1;
    chk("exec_busy", 64'(bus.busy), 64'd1);
    chk("exec_no_done", 64'(bus.done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    #1;
    chk("midreset_outputs", all_outs(), 64'd0);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    run(mk_alu(32'h20200001, 1, 5'd1, 5'd0, 5'd0, 32'h00000001, 1, 1, 4'd0, 0, 0));

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
